flow_led_ctrl: RTL and testbench
================================

Name: flow_led_ctrl

Overview:
- Sequencing controller for the FluentLight running-light datapath.
- Synchronises the RightLeft and Pause switches, resolves the direction/pause/reset mode, and divides the system clock into step ticks.
- Rotates a one-hot LED pattern one position per tick.
- Sits between the board switches and the LED pins; its mode encoding is 00 hold, 01 init, 10 right, 11 left.

Parameters:
- N, 16: LED count / pattern width (N >= 2).
- BASE_DIV, 25_000_000: clock cycles per step at Speed=0 (>= 2).
- CNT_W, 32: prescaler counter width; must hold BASE_DIV*8 - 1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  reset Reset, synchronous, active-high.
- RightLeft  input  1  async switch: 0 = rotate right (toward LSB), 1 = rotate left (toward MSB).
- Pause  input  1  async switch: 1 = freeze pattern and prescaler.
- Speed  input  2  step period select, sampled each cycle.
- Led  output  N  one-hot LED pattern.
- Step  output  1  one-cycle pulse, high in the cycle Led has just moved.
- Mode  output  2  current state: 00 HOLD, 01 INIT, 10 RUN_R, 11 RUN_L.

Behaviour:
- Reset (checked at Clk edge, dominates everything):
  - Led = 1 (bit 0 set), Step = 0, Mode = INIT (01).
  - Prescaler count = 0; both synchroniser stages = 0.
- Synchronisers:
  - Two flops each on RightLeft and Pause.
  - The state register adds one more cycle, so a switch change is visible on Mode 3 cycles after it is sampled.
- State machine (registered):
  - INIT: exactly one cycle after Reset drops. Next state is HOLD if sync Pause=1, else RUN_R or RUN_L per sync RightLeft.
  - HOLD: go to RUN_R or RUN_L when sync Pause=0.
  - RUN_R / RUN_L: go to HOLD when sync Pause=1; otherwise switch between RUN_R and RUN_L directly when sync RightLeft changes.
  - Priority: Reset > Pause > RightLeft.
- Prescaler:
  - Period P = BASE_DIV << Speed (Speed 0..3 gives x1, x2, x4, x8).
  - Counts only in RUN_R or RUN_L; holds its value in HOLD; forced to 0 in INIT and on Reset.
  - Tick when count >= P-1; count then returns to 0. The >= comparison makes a Speed decrease mid-count tick on the next cycle, never after a counter wrap.
- Step and Led:
  - On the tick edge, Led rotates and Step is registered high for exactly one cycle.
  - RUN_R: Led = {Led[0], Led[N-1:1]}; wraps bit 0 to bit N-1.
  - RUN_L: Led = {Led[N-2:0], Led[N-1]}; wraps bit N-1 to bit 0.
  - Direction used is the state at the tick edge. A direction change does not clear the prescaler; the new direction applies at the next tick.
- Pause and resume: in HOLD, Led and count freeze. On resume the count continues, so the first step comes P minus the frozen count cycles later.
- Invariants:
  - Led is always one-hot, including across reset. Any non-one-hot value is an RTL bug (assertion in the bench).
  - Step is never high in HOLD or INIT.
- Reset mid-run: pattern returns to 1 on the next edge. Any Step pulse in flight is cancelled (Step = 0 in the reset cycle).

Decomposition:
- Package flow_led_pkg:
  - Mode encodings MODE_HOLD=2'b00, MODE_INIT=2'b01, MODE_RUN_R=2'b10, MODE_RUN_L=2'b11.
  - Speed shift limit constant (3).
- One sub-module, step_prescaler:
  - Inputs: Clk, Reset, enable, clear, Speed.
  - Output: tick.
  - Parameters: BASE_DIV, CNT_W.
  - Contains the >= comparison.
- State machine, synchronisers and rotate register stay in flow_led_ctrl.

Test Plan:
All scenarios use N=8, BASE_DIV=4.
- Power-up: hold Reset 3 cycles with Pause=0, RightLeft=0, Speed=0, then release.
  - Mode = 01 for one cycle, then 10.
  - Led goes 0x01 → 0x80 → 0x40, with Step pulses exactly 4 cycles apart.
- Left wrap: RightLeft=1, run 8 ticks from 0x01.
  - Led goes 0x02, 0x04, … 0x80, 0x01; one Step per transition.
- Pause mid-count: assert Pause 2 cycles after a tick, hold 20 cycles, release.
  - Mode = 00 within 3 cycles; Led unchanged and no Step while paused.
  - First Step after Mode returns to 10/11 arrives after the remaining count (not a full 4 cycles).
- Speed change: Speed=3 (P=32); at count 20 switch to Speed=0.
  - Tick on the next cycle, then every 4 cycles.
- Direction flip between ticks: RUN_R with Led=0x10; flip RightLeft 1 cycle after a tick.
  - Next tick gives Led=0x20 after the same 4-cycle period; no extra or missed Step.
- Reset in the Step cycle: assert Reset on the edge following a tick.
  - Led = 0x01, Step = 0, Mode = 01 the following cycle; count restarts from 0.

Source files
------------

// File: rtl/flow_led_pkg.sv
// Shared definitions for the FluentLight running-light sequencer.
package flow_led_pkg;

    // Mode encoding as presented on the Mode output pins.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_INIT  = 2'b01,
        MODE_RUN_R = 2'b10,
        MODE_RUN_L = 2'b11
    } mode_t;

    // Largest Speed shift: step period ranges from BASE_DIV up to BASE_DIV << 3.
    localparam int unsigned SPEED_SHIFT_MAX = 3;

    // True for the two states in which the pattern is allowed to move.
    function automatic logic is_run(input mode_t m);
        return m[1];
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-period divider: counts enabled cycles and raises tick on the last
// cycle of each period. Period is BASE_DIV << Speed.
module step_prescaler
    import flow_led_pkg::*;
#(
    parameter int unsigned BASE_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] Speed,
    output logic       tick
);

    logic [CNT_W-1:0]                       count_r;
    logic [CNT_W-1:0]                       last_s;
    logic [$clog2(SPEED_SHIFT_MAX+1)-1:0]   shift_s;

    // Terminal count for the current speed; >= lets a speed decrease
    // mid-period fire on the next cycle instead of wrapping the counter.
    always_comb begin
        shift_s = Speed;
        last_s  = (CNT_W'(BASE_DIV) << shift_s) - CNT_W'(1);
        tick    = enable && (count_r >= last_s);
    end

    // Period counter: cleared on reset/clear, frozen while disabled.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count_r <= '0;
        end else if (enable) begin
            if (tick) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/flow_led_ctrl.sv
// Running-light sequencer: synchronises the board switches, resolves the
// hold/init/run-right/run-left mode and rotates a one-hot LED pattern on
// every prescaler tick.
module flow_led_ctrl
    import flow_led_pkg::*;
#(
    parameter int unsigned N        = 16,
    parameter int unsigned BASE_DIV = 25_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         RightLeft,
    input  logic         Pause,
    input  logic [1:0]   Speed,
    output logic [N-1:0] Led,
    output logic         Step,
    output logic [1:0]   Mode
);

    logic [1:0]   rl_sync_r;
    logic [1:0]   pause_sync_r;
    mode_t        mode_r;
    logic [N-1:0] led_r;
    logic         step_r;
    logic         tick_s;
    logic         run_en_s;
    logic         clear_s;
    mode_t        run_dir_s;

    // Two-flop synchronisers for the asynchronous board switches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rl_sync_r    <= 2'b00;
            pause_sync_r <= 2'b00;
        end else begin
            rl_sync_r    <= {rl_sync_r[0], RightLeft};
            pause_sync_r <= {pause_sync_r[0], Pause};
        end
    end

    // Prescaler control; counting stops as soon as a pause is seen so no
    // step can land in the same edge that enters HOLD.
    always_comb begin
        run_en_s = is_run(mode_r) && !pause_sync_r[1];
        clear_s  = (mode_r == MODE_INIT);
        if (rl_sync_r[1]) begin
            run_dir_s = MODE_RUN_L;
        end else begin
            run_dir_s = MODE_RUN_R;
        end
    end

    step_prescaler #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .Clk    (Clk),
        .Reset  (Reset),
        .enable (run_en_s),
        .clear  (clear_s),
        .Speed  (Speed),
        .tick   (tick_s)
    );

    // Mode state machine with the registered LED pattern and step pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mode_r <= MODE_INIT;
            led_r  <= {{(N-1){1'b0}}, 1'b1};
            step_r <= 1'b0;
        end else begin
            step_r <= tick_s;
            if (tick_s) begin
                if (mode_r == MODE_RUN_L) begin
                    led_r <= {led_r[N-2:0], led_r[N-1]};
                end else begin
                    led_r <= {led_r[0], led_r[N-1:1]};
                end
            end else begin
                led_r <= led_r;
            end
            case (mode_r)
                MODE_INIT: begin
                    if (pause_sync_r[1]) mode_r <= MODE_HOLD;
                    else                 mode_r <= run_dir_s;
                end
                MODE_HOLD: begin
                    if (pause_sync_r[1]) mode_r <= MODE_HOLD;
                    else                 mode_r <= run_dir_s;
                end
                MODE_RUN_R, MODE_RUN_L: begin
                    if (pause_sync_r[1]) mode_r <= MODE_HOLD;
                    else                 mode_r <= run_dir_s;
                end
                default: mode_r <= MODE_INIT;
            endcase
        end
    end

    assign Led  = led_r;
    assign Step = step_r;
    assign Mode = mode_r;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// Self-checking bench for flow_led_ctrl (N=8, BASE_DIV=4).
module tb_flow_led_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       RightLeft = 1'b0;
    logic       Pause = 1'b0;
    logic [1:0] Speed = 2'd0;
    logic [7:0] Led;
    logic       Step;
    logic [1:0] Mode;

    int n_cmp = 0;
    int n_bad = 0;

    flow_led_ctrl #(.N(8), .BASE_DIV(4), .CNT_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RightLeft (RightLeft),
        .Pause     (Pause),
        .Speed     (Speed),
        .Led       (Led),
        .Step      (Step),
        .Mode      (Mode)
    );

    always #5 Clk = ~Clk;

    // Reference model: LED position as an index, modes as spec values.
    int   m_pos, m_cnt, m_mode;
    logic m_step;
    logic p_d1, p_d2, r_d1, r_d2;

    task automatic model_edge(input logic r, input logic rl, input logic p, input logic [1:0] sp);
        int  period;
        logic adv, tk;
        if (r) begin
            m_pos = 0; m_step = 1'b0; m_mode = 1; m_cnt = 0;
            p_d1 = 1'b0; p_d2 = 1'b0; r_d1 = 1'b0; r_d2 = 1'b0;
        end else begin
            period = 4 << sp;
            adv    = (m_mode >= 2) && !p_d2;
            tk     = adv && (m_cnt >= period - 1);
            m_step = tk;
            if (tk) m_pos = (m_mode == 3) ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
            if (m_mode == 1) m_cnt = 0;
            else if (adv)    m_cnt = tk ? 0 : m_cnt + 1;
            m_mode = p_d2 ? 0 : (r_d2 ? 3 : 2);
            p_d2 = p_d1; p_d1 = p;
            r_d2 = r_d1; r_d1 = rl;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare after the edge.
    task automatic cycle(input logic r, input logic rl, input logic p, input logic [1:0] sp);
        logic [7:0] one;
        one = 8'h01;
        Reset = r; RightLeft = rl; Pause = p; Speed = sp;
        @(posedge Clk);
        model_edge(r, rl, p, sp);
        #1;
        chk("mdl_led", Led, one << m_pos);
        chk("mdl_step", Step, m_step);
        chk("mdl_mode", Mode, m_mode[1:0]);
        chk("onehot", $onehot(Led), 1);
        chk("step_idle", Step && (Mode == 2'b00 || Mode == 2'b01), 0);
    endtask

    task automatic wait_step(input logic rl, input logic p, input logic [1:0] sp, input int max, output int n);
        n = 0;
        for (int k = 0; k < max; k++) begin
            cycle(1'b0, rl, p, sp);
            n++;
            if (Step === 1'b1) break;
        end
        if (Step !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_step: no Step within %0d cycles", max);
            n = -1;
        end
    endtask

    typedef struct {
        logic       rst;
        logic       rl;
        logic       pause;
        logic [1:0] speed;
        logic [7:0] led;
        logic       step;
        logic [1:0] mode;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        logic [7:0] one, led_hold, exp_led;
        logic r, rl, p;
        logic [1:0] sp;
        logic found;
        one = 8'h01;

        // Power-up: 3 reset cycles, INIT for one cycle, steps 4 apart.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b01};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b01};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b01};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b10};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b10};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b10};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, 2'b10};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h80, 1'b1, 2'b10};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h80, 1'b0, 2'b10};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h80, 1'b0, 2'b10};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h80, 1'b0, 2'b10};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h40, 1'b1, 2'b10};
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].rst, vecs[i].rl, vecs[i].pause, vecs[i].speed);
            chk($sformatf("tbl%0d_led", i), Led, vecs[i].led);
            chk($sformatf("tbl%0d_step", i), Step, vecs[i].step);
            chk($sformatf("tbl%0d_mode", i), Mode, vecs[i].mode);
        end

        // Left wrap: restart from 0x01 with RightLeft=1, eight steps.
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 8; k++) begin
            wait_step(1'b1, 1'b0, 2'd0, 20, n);
            chk("wrap_gap", n, (k == 1) ? 5 : 4);
            exp_led = one << (k % 8);
            chk("wrap_led", Led, exp_led);
        end

        // Pause two cycles after a tick; resume finishes the remaining count.
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        led_hold = Led;
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 2'd0);
            if (k == 3) chk("pause_mode", Mode, 2'b00);
            chk("pause_led", Led, led_hold);
            chk("pause_step", Step, 0);
        end
        for (int k = 0; k < 10 && Mode == 2'b00; k++) cycle(1'b0, 1'b1, 1'b0, 2'd0);
        chk("resume_mode", Mode, 2'b11);
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        chk("resume_gap", n, 1);
        exp_led = {led_hold[6:0], led_hold[7]};
        chk("resume_led", Led, exp_led);

        // Speed change: P=32, at count 20 drop to Speed=0.
        wait_step(1'b1, 1'b0, 2'd3, 100, n);
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 2'd3);
            chk("spd_quiet", Step, 0);
        end
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        chk("spd_fast_tick", Step, 1);
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        chk("spd_gap1", n, 4);
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        chk("spd_gap2", n, 4);

        // Direction flip one cycle after the tick that landed on 0x10.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 2'd0);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 2'd0);
            found = (Step === 1'b1) && (Led === 8'h10) && (Mode === 2'b10);
        end
        chk("dir_found", found, 1);
        cycle(1'b0, 1'b1, 1'b0, 2'd0);
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        chk("dir_gap", n + 1, 4);
        chk("dir_led", Led, 8'h20);

        // Reset on the edge right after a tick.
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        cycle(1'b1, 1'b1, 1'b0, 2'd0);
        chk("rst_led", Led, 8'h01);
        chk("rst_step", Step, 0);
        chk("rst_mode", Mode, 2'b01);
        wait_step(1'b1, 1'b0, 2'd0, 20, n);
        chk("rst_restart_gap", n, 5);
        chk("rst_restart_led", Led, 8'h02);

        // Randomised soak against the model.
        r = 1'b0; rl = 1'b0; p = 1'b0; sp = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) rl = ~rl;
            if ($urandom_range(0, 19) == 0) p = ~p;
            if ($urandom_range(0, 31) == 0) sp = 2'($urandom_range(0, 3));
            cycle(r, rl, p, sp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
